mm_controller: RTL and testbench

Parametrised sequencing controller for the systolic matrix-multiplier datapath; generalises the fixed 8×8 controller to any square dimension. It fetches both operand matrices from ROM/RAM into the register banks, then runs a LOAD→MAC→STORE loop per output element, and exposes a start/done handshake with stall and abort. It sits between the top-level host interface and the operand memories, register banks and MAC array.

---
 rtl/mm_controller.sv | 187 ++++++++++++++++++
 tb/tb_mm_controller.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_controller.sv
// Purpose : sequencing controller for an N x N systolic matrix multiplier; fetches both
//           operands into the register banks, then runs LOAD -> MAC -> STORE per output element.
// Latency : done pulses DIM*DIM + RD_LAT + DIM*DIM*(DIM+2) + 1 cycles after start is accepted.
// Backpressure: i_enable low freezes state, counters and every output; i_abort returns to IDLE.
// Ports   : i_clk/i_reset_n (async active-low), i_enable, i_start, i_abort in;
//           o_busy, o_done, o_read_en/o_rd_addr/o_bank_select_line/o_select_line (operand fetch),
//           o_acc_clr/o_mac_en/o_k_idx (MAC array), o_out_row/o_out_col/o_wr_en/o_wr_addr (result).
// Option  : define MM_CTRL_PERF_CNT_EN to add o_cycle_count (saturating busy-cycle counter).
module mm_controller #(
    parameter int DIM    = 8,
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 4,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [SEL_W-1:0]  o_bank_select_line,
    output logic [SEL_W-1:0]  o_select_line,
    output logic              o_acc_clr,
    output logic              o_mac_en,
    output logic [SEL_W-1:0]  o_k_idx,
    output logic [SEL_W-1:0]  o_out_row,
    output logic [SEL_W-1:0]  o_out_col,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr
`ifdef MM_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       o_cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_DRAIN, S_LOAD, S_MAC, S_STORE, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DIM * DIM - 1);
    localparam logic [SEL_W-1:0]  LAST_IDX   = SEL_W'(DIM - 1);
    localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [SEL_W-1:0]  r_bank;
    logic [SEL_W-1:0]  r_sel;
    logic [2:0]        r_drain_cnt;
    logic [SEL_W-1:0]  r_k;
    logic [SEL_W-1:0]  r_i;
    logic [SEL_W-1:0]  r_j;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_read_en;
    logic              r_acc_clr;
    logic              r_mac_en;
    logic              r_wr_en;
    logic              r_done;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else if (i_enable) begin
            r_state <= w_state_nxt;
        end
    end

    // Abort has priority over everything, including a start seen in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_state_nxt = S_READ;
                S_READ:  if (r_rd_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
                S_DRAIN: if (r_drain_cnt == LAST_DRAIN) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = S_MAC;
                S_MAC:   if (r_k == LAST_IDX) w_state_nxt = S_STORE;
                S_STORE: w_state_nxt = (r_i == LAST_IDX && r_j == LAST_IDX) ? S_DONE : S_LOAD;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so each is high exactly while in its state.
    // Every counter is zeroed on any entry to IDLE, so IDLE always starts a run from zero.
    // The result address runs as a counter: elements are stored row-major, so it equals i*DIM+j.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_read_en   <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_done      <= 1'b0;
            r_rd_addr   <= '0;
            r_bank      <= '0;
            r_sel       <= '0;
            r_drain_cnt <= '0;
            r_k         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_wr_addr   <= '0;
        end else if (i_enable) begin
            r_read_en <= (w_state_nxt == S_READ);
            r_acc_clr <= (w_state_nxt == S_LOAD);
            r_mac_en  <= (w_state_nxt == S_MAC);
            r_wr_en   <= (w_state_nxt == S_STORE);
            r_done    <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_IDLE) begin
                r_rd_addr   <= '0;
                r_bank      <= '0;
                r_sel       <= '0;
                r_drain_cnt <= '0;
                r_k         <= '0;
                r_i         <= '0;
                r_j         <= '0;
                r_wr_addr   <= '0;
            end else begin
                case (r_state)
                    S_READ: begin
                        if (r_rd_addr != LAST_ADDR) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            if (r_sel == LAST_IDX) begin
                                r_sel  <= '0;
                                r_bank <= r_bank + 1'b1;
                            end else begin
                                r_sel <= r_sel + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: r_drain_cnt <= r_drain_cnt + 1'b1;
                    S_LOAD:  r_k <= '0;
                    S_MAC:   if (r_k != LAST_IDX) r_k <= r_k + 1'b1;
                    S_STORE: begin
                        if (r_j == LAST_IDX) begin
                            r_j <= '0;
                            r_i <= (r_i == LAST_IDX) ? '0 : r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                        if (r_wr_addr != LAST_ADDR) r_wr_addr <= r_wr_addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MM_CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;

    // Counts enabled cycles spent outside IDLE; the DONE cycle is the last one counted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cycle_cnt <= '0;
        end else if (i_enable) begin
            if (r_state == S_IDLE && w_state_nxt == S_READ) begin
                r_cycle_cnt <= '0;
            end else if (r_state != S_IDLE && r_cycle_cnt != '1) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
        end
    end

    assign o_cycle_count = r_cycle_cnt;
`endif

    assign o_busy             = (r_state != S_IDLE);
    assign o_done             = r_done;
    assign o_read_en          = r_read_en;
    assign o_rd_addr          = r_rd_addr;
    assign o_bank_select_line = r_bank;
    assign o_select_line      = r_sel;
    assign o_acc_clr          = r_acc_clr;
    assign o_mac_en           = r_mac_en;
    assign o_k_idx            = r_k;
    assign o_out_row          = r_i;
    assign o_out_col          = r_j;
    assign o_wr_en            = r_wr_en;
    assign o_wr_addr          = r_wr_addr;

endmodule

// File: tb/tb_mm_controller.sv
// Purpose : self-checking bench for mm_controller (DIM=2 instance plus a default DIM=8 instance).
// Latency : expected done cycle derived from the timing formula for each run.
// Backpressure: exercises enable stalls, abort and held start.
module tb_mm_controller;

    localparam int N   = 2;
    localparam int RL  = 2;
    localparam int N8  = 8;
    localparam int T2  = N * N + RL + N * N * (N + 2) + 1;
    localparam int T8  = N8 * N8 + 2 + N8 * N8 * (N8 + 2) + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       start;
    logic       abort;
    logic       start8;
    logic       busy, done, read_en, acc_clr, mac_en, wr_en;
    logic [7:0] rd_addr, wr_addr;
    logic [3:0] bank, sel, k_idx, out_row, out_col;
    logic       busy8, done8, read_en8, acc_clr8, mac_en8, wr_en8;
    logic [7:0] rd_addr8, wr_addr8;
    logic [3:0] bank8, sel8, k8, row8, col8;
`ifdef MM_CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, cyc_cnt8;
`endif

    mm_controller #(.DIM(N), .ADDR_W(8), .SEL_W(4), .RD_LAT(RL)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_done(done), .o_read_en(read_en), .o_rd_addr(rd_addr),
        .o_bank_select_line(bank), .o_select_line(sel), .o_acc_clr(acc_clr), .o_mac_en(mac_en),
        .o_k_idx(k_idx), .o_out_row(out_row), .o_out_col(out_col), .o_wr_en(wr_en),
        .o_wr_addr(wr_addr)
`ifdef MM_CTRL_PERF_CNT_EN
        , .o_cycle_count(cyc_cnt)
`endif
    );

    mm_controller u_dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(1'b1), .i_start(start8), .i_abort(1'b0),
        .o_busy(busy8), .o_done(done8), .o_read_en(read_en8), .o_rd_addr(rd_addr8),
        .o_bank_select_line(bank8), .o_select_line(sel8), .o_acc_clr(acc_clr8), .o_mac_en(mac_en8),
        .o_k_idx(k8), .o_out_row(row8), .o_out_col(col8), .o_wr_en(wr_en8),
        .o_wr_addr(wr_addr8)
`ifdef MM_CTRL_PERF_CNT_EN
        , .o_cycle_count(cyc_cnt8)
`endif
    );

    always #5 clk = ~clk;

    logic [41:0] outs2, outs8;
    assign outs2 = {busy, done, read_en, rd_addr, bank, sel, acc_clr, mac_en, k_idx,
                    out_row, out_col, wr_en, wr_addr};
    assign outs8 = {busy8, done8, read_en8, rd_addr8, bank8, sel8, acc_clr8, mac_en8, k8,
                    row8, col8, wr_en8, wr_addr8};

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;
    bit adv      = 1'b0;

    int q_rd[$], q_acc[$], q_k[$], q_wr[$], q_done[$];
    int q8_rd[$], q8_wr[$], q8_done[$];
    int mon_a, mon8_a;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        tb_cyc <= tb_cyc + 1;
        adv    <= enable;
    end

    // Scoreboard for the DIM=2 instance; skips cycles that followed a stalled edge.
    always @(negedge clk) begin
        if (rst_n && adv) begin
            if (read_en) begin
                if (q_rd.size() == 0) check_val("rd_unexpected", read_en, 0);
                else begin
                    mon_a = q_rd.pop_front();
                    check_val("rd_addr", rd_addr, mon_a);
                    check_val("bank_sel", bank, mon_a / N);
                    check_val("col_sel", sel, mon_a % N);
                end
            end
            if (acc_clr) begin
                if (q_acc.size() == 0) check_val("acc_unexpected", acc_clr, 0);
                else mon_a = q_acc.pop_front();
            end
            if (mac_en) begin
                if (q_k.size() == 0) check_val("mac_unexpected", mac_en, 0);
                else begin
                    mon_a = q_k.pop_front();
                    check_val("k_idx", k_idx, mon_a);
                end
            end
            if (wr_en) begin
                if (q_wr.size() == 0) check_val("wr_unexpected", wr_en, 0);
                else begin
                    mon_a = q_wr.pop_front();
                    check_val("wr_addr", wr_addr, mon_a);
                    check_val("out_row", out_row, mon_a / N);
                    check_val("out_col", out_col, mon_a % N);
                end
            end
            if (done) begin
                if (q_done.size() == 0) check_val("done_unexpected", done, 0);
                else begin
                    mon_a = q_done.pop_front();
                    check_val("done_cycle", tb_cyc, mon_a);
                end
            end
        end
    end

    // Scoreboard for the DIM=8 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (read_en8) begin
                if (q8_rd.size() == 0) check_val("rd8_unexpected", read_en8, 0);
                else begin
                    mon8_a = q8_rd.pop_front();
                    check_val("rd8_addr", rd_addr8, mon8_a);
                    check_val("bank8_sel", bank8, mon8_a / N8);
                    check_val("col8_sel", sel8, mon8_a % N8);
                end
            end
            if (wr_en8) begin
                if (q8_wr.size() == 0) check_val("wr8_unexpected", wr_en8, 0);
                else begin
                    mon8_a = q8_wr.pop_front();
                    check_val("wr8_addr", wr_addr8, mon8_a);
                end
            end
            if (done8) begin
                if (q8_done.size() == 0) check_val("done8_unexpected", done8, 0);
                else begin
                    mon8_a = q8_done.pop_front();
                    check_val("done8_cycle", tb_cyc, mon8_a);
                end
            end
        end
    end

    task automatic push2(input int elems, input bit with_done, input int done_at);
        for (int a = 0; a < N * N; a++) q_rd.push_back(a);
        for (int e = 0; e < elems; e++) begin
            q_acc.push_back(e);
            for (int k = 0; k < N; k++) q_k.push_back(k);
            q_wr.push_back(e);
        end
        if (with_done) q_done.push_back(done_at);
    endtask

    task automatic start2(output int e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e = tb_cyc;
        start = 1'b0;
    endtask

    function automatic int pending2();
        return q_rd.size() + q_acc.size() + q_k.size() + q_wr.size() + q_done.size();
    endfunction

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (pending2() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_val(tag, pending2(), 0);
    endtask

    initial begin
        int e;
        int n;
        logic [41:0] snap;
        rst_n  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", outs2, 0);
        check_val("reset_outs8", outs8, 0);
        rst_n = 1'b1;

        // Basic run: done in cycle T2 after acceptance.
        start2(e);
        push2(N * N, 1'b1, e + T2 - 1);
        wait_empty("basic_pending", 300);
        @(negedge clk);
        check_val("basic_busy_drop", busy, 0);
`ifdef MM_CTRL_PERF_CNT_EN
        check_val("perf_basic", cyc_cnt, T2);
`endif

        // Three-cycle stall in the middle of MAC; outputs must not move.
        start2(e);
        push2(N * N, 1'b1, e + T2 - 1 + 3);
        n = 0;
        while (!mac_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("stall_reach_mac", mac_en, 1);
        snap = outs2;
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("stall_frozen", outs2, snap);
        end
        enable = 1'b1;
        wait_empty("stall_pending", 300);
        @(negedge clk);
        check_val("stall_busy_drop", busy, 0);
`ifdef MM_CTRL_PERF_CNT_EN
        check_val("perf_stall", cyc_cnt, T2);
`endif

        // Abort during STORE of element (0,1).
        start2(e);
        push2(2, 1'b0, 0);
        n = 0;
        while (!(wr_en && wr_addr == 8'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_reach_store", wr_en, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_strobes", {done, wr_en, read_en, acc_clr, mac_en}, 0);
        repeat (6) @(negedge clk);
        check_val("abort_idle", busy, 0);
        wait_empty("abort_pending", 5);

        // Clean run after abort.
        start2(e);
        push2(N * N, 1'b1, e + T2 - 1);
        wait_empty("post_abort_pending", 300);

        // Start held high: one done per accepted start, second start accepted right after DONE.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e = tb_cyc;
        push2(N * N, 1'b1, e + T2 - 1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("held_first_done", done, 1);
        push2(N * N, 1'b1, tb_cyc + 2 + T2 - 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty("held_pending", 300);
        repeat (4) @(negedge clk);
        check_val("held_no_restart", busy, 0);

        // Start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_idle", busy, 0);
        @(negedge clk);
        check_val("start_abort_idle2", busy, 0);

        // Default DIM=8 instance.
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        e = tb_cyc;
        start8 = 1'b0;
        for (int a = 0; a < N8 * N8; a++) begin
            q8_rd.push_back(a);
            q8_wr.push_back(a);
        end
        q8_done.push_back(e + T8 - 1);
        n = 0;
        while ((q8_rd.size() + q8_wr.size() + q8_done.size()) != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check_val("dim8_pending", q8_rd.size() + q8_wr.size() + q8_done.size(), 0);
        @(negedge clk);
        check_val("dim8_busy_drop", busy8, 0);
        check_val("dim2_idle_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
